mmio_console: RTL and testbench



---
 rtl/ice_risc_mmio_pkg.sv | 15 +
 rtl/uart_tx_8n1.sv | 85 ++++++++
 rtl/mmio_console.sv | 106 ++++++++++
 tb/tb_mmio_console.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/ice_risc_mmio_pkg.sv
// Shared definitions for the MMIO console/halt peripheral: default register
// addresses and the UART serialiser state encoding.
package ice_risc_mmio_pkg;

  localparam logic [31:0] CONSOLE_ADDR_DEF = 32'h1000_0000;
  localparam logic [31:0] HALT_ADDR_DEF    = 32'h1000_0004;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_tx_8n1.sv
// 8N1 UART serialiser with a valid/ready byte input; accepts a byte only
// while idle and drives the line from a registered output.
module uart_tx_8n1
  import ice_risc_mmio_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       valid_i,
  input  logic [7:0] data_i,
  output logic       ready_o,
  output logic       tx_o
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  tx_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_q;
  logic [7:0]       shift_q;
  logic             tx_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      tx_q    <= 1'b1;
      cnt_q   <= '0;
      bit_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (valid_i) begin
            shift_q <= data_i;
            state_q <= ST_START;
            tx_q    <= 1'b0;
            cnt_q   <= '0;
          end
        end
        ST_START: begin
          if (cnt_q == CNT_LAST) begin
            state_q <= ST_DATA;
            tx_q    <= shift_q[0];
            bit_q   <= '0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_DATA: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
            if (bit_q == 3'd7) begin
              state_q <= ST_STOP;
              tx_q    <= 1'b1;
            end else begin
              bit_q <= bit_q + 3'd1;
              tx_q  <= shift_q[bit_q + 3'd1];
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_STOP: begin
          if (cnt_q == CNT_LAST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          tx_q    <= 1'b1;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign ready_o = (state_q == ST_IDLE);
  assign tx_o    = tx_q;

endmodule

// File: rtl/mmio_console.sv
// Store-port snooper: decodes console/halt stores, buffers console bytes in
// a small FIFO feeding the UART serialiser, and keeps sticky halt/overflow.
module mmio_console
  import ice_risc_mmio_pkg::*;
#(
  parameter logic [31:0] CONSOLE_ADDR = CONSOLE_ADDR_DEF,
  parameter logic [31:0] HALT_ADDR    = HALT_ADDR_DEF,
  parameter int          FIFO_DEPTH   = 8,
  parameter int          CLKS_PER_BIT = 4
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic [31:0] iWriteAddr,
  input  logic [31:0] iWriteData,
  input  logic [3:0]  iWstrb,
  output logic        oTx,
  output logic        oHalt,
  output logic [7:0]  oHaltCode,
  output logic        oOverflow,
  output logic        oDrained
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             halt_q, halt_d;
  logic [7:0]       code_q, code_d;
  logic             ovf_q, ovf_d;

  logic console_we, halt_we, full, push, pop, tx_ready;
  logic unused_bits;

  assign unused_bits = ^{iWriteData[31:8], iWstrb[3:1]};

  assign console_we = iWstrb[0] && (iWriteAddr == CONSOLE_ADDR);
  assign halt_we    = iWstrb[0] && (iWriteAddr == HALT_ADDR);
  assign full       = (count_q == CNT_FULL);
  assign pop        = (count_q != '0) && tx_ready;
  // A pop on the same edge frees the slot, so a push into a full FIFO is kept.
  assign push       = console_we && (!full || pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    halt_d   = halt_q;
    code_d   = code_q;
    ovf_d    = ovf_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (console_we && !push) ovf_d = 1'b1;
    if (halt_we && !halt_q) begin
      halt_d = 1'b1;
      code_d = iWriteData[7:0];
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      halt_q   <= 1'b0;
      code_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      halt_q   <= halt_d;
      code_q   <= code_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge iClk) begin
    if (push) mem_q[wr_ptr_q] <= iWriteData[7:0];
  end

  uart_tx_8n1 #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk_i  (iClk),
    .rst_i  (iRst),
    .valid_i(count_q != '0),
    .data_i (mem_q[rd_ptr_q]),
    .ready_o(tx_ready),
    .tx_o   (oTx)
  );

  assign oHalt     = halt_q;
  assign oHaltCode = code_q;
  assign oOverflow = ovf_q;
  assign oDrained  = halt_q && (count_q == '0) && tx_ready;

endmodule

// File: tb/tb_mmio_console.sv
// Randomised and directed stimulus for mmio_console against a frame-level
// reference model (byte queue plus transmitter position within a frame).
module tb_mmio_console;

  localparam logic [31:0] CON  = 32'h1000_0000;
  localparam logic [31:0] HLT  = 32'h1000_0004;
  localparam int          DEPTH = 8;
  localparam int          CPB   = 4;
  localparam int          FRAME = 10 * CPB;

  logic        iClk = 1'b0;
  logic        iRst = 1'b1;
  logic [31:0] iWriteAddr = '0;
  logic [31:0] iWriteData = '0;
  logic [3:0]  iWstrb = '0;
  logic        oTx, oHalt, oOverflow, oDrained;
  logic [7:0]  oHaltCode;

  int checks = 0;
  int errors = 0;

  // Reference model state
  byte unsigned q[$];
  bit           busy;
  int           pos;
  byte unsigned cur;
  bit           m_halt;
  byte unsigned m_code;
  bit           m_ovf;

  mmio_console #(
    .CONSOLE_ADDR(CON),
    .HALT_ADDR   (HLT),
    .FIFO_DEPTH  (DEPTH),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .iClk      (iClk),
    .iRst      (iRst),
    .iWriteAddr(iWriteAddr),
    .iWriteData(iWriteData),
    .iWstrb    (iWstrb),
    .oTx       (oTx),
    .oHalt     (oHalt),
    .oHaltCode (oHaltCode),
    .oOverflow (oOverflow),
    .oDrained  (oDrained)
  );

  always #5 iClk = ~iClk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic bit exp_tx();
    if (!busy)               return 1'b1;
    if (pos < CPB)           return 1'b0;
    if (pos < 9 * CPB)       return cur[(pos - CPB) / CPB];
    return 1'b1;
  endfunction

  task automatic model_edge(input bit rst, input logic [31:0] addr,
                            input logic [31:0] data, input logic [3:0] strb);
    bit pop;
    int pre;
    if (rst) begin
      q.delete();
      busy = 0; pos = 0; m_halt = 0; m_code = 0; m_ovf = 0;
    end else begin
      pop = !busy && (q.size() != 0);
      pre = q.size();
      if (busy) begin
        pos++;
        if (pos == FRAME) busy = 0;
      end
      if (pop) begin
        cur = q.pop_front();
        busy = 1;
        pos = 0;
      end
      if (strb[0] && addr == CON) begin
        if (pre < DEPTH || pop) q.push_back(data[7:0]);
        else m_ovf = 1;
      end
      if (strb[0] && addr == HLT && !m_halt) begin
        m_halt = 1;
        m_code = data[7:0];
      end
    end
  endtask

  task automatic cycle(input bit rst, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] strb);
    iRst = rst; iWriteAddr = addr; iWriteData = data; iWstrb = strb;
    @(posedge iClk);
    model_edge(rst, addr, data, strb);
    @(negedge iClk);
    chk("tx", oTx, exp_tx());
    chk("halt", oHalt, m_halt);
    chk("halt_code", oHaltCode, m_code);
    chk("overflow", oOverflow, m_ovf);
    chk("drained", oDrained, m_halt && q.size() == 0 && !busy);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 4'b0000);
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data);
    cycle(1'b0, addr, data, 4'b0001);
  endtask

  task automatic do_reset();
    cycle(1'b1, '0, '0, 4'b0000);
    cycle(1'b1, '0, '0, 4'b0000);
  endtask

  initial begin
    int waited;
    logic [31:0] a;
    do_reset();

    // Single byte
    store(CON, 32'h0000_0041);
    idle(FRAME + 5);

    // Burst with overflow
    for (int i = 0; i < 10; i++) store(CON, 32'h30 + i);
    chk("burst_ovf", oOverflow, 1'b1);
    idle(9 * (FRAME + 1) + 5);

    // Full FIFO with a push landing on the pop edge
    do_reset();
    for (int i = 0; i < 9; i++) store(CON, 32'h60 + i);
    waited = 0;
    while (!(!busy && q.size() == DEPTH) && waited < 200) begin
      idle(1);
      waited++;
    end
    chk("wait_full_pop", (waited < 200), 1'b1);
    store(CON, 32'h0000_00AA);
    chk("full_pop_no_ovf", oOverflow, 1'b0);
    idle(9 * (FRAME + 1) + 5);

    // Halt with two bytes queued, first code wins
    do_reset();
    store(CON, 32'h0000_0048);
    store(CON, 32'h0000_0069);
    store(HLT, 32'h0000_002A);
    chk("halt_set", oHalt, 1'b1);
    chk("halt_code_2a", oHaltCode, 8'h2A);
    store(HLT, 32'h0000_0055);
    chk("halt_code_keep", oHaltCode, 8'h2A);
    idle(2 * (FRAME + 1) + 5);
    chk("drained_final", oDrained, 1'b1);

    // Ignored stores
    do_reset();
    cycle(1'b0, CON, 32'h0000_0041, 4'b0010);
    cycle(1'b0, CON + 8, 32'h0000_0041, 4'b0001);
    cycle(1'b0, CON, 32'h0000_0041, 4'b0000);
    idle(FRAME);

    // Reset mid-frame during DATA bit3
    for (int i = 0; i < 3; i++) store(CON, 32'h51 + i);
    waited = 0;
    while (!(busy && pos == 4 * CPB + 1) && waited < 200) begin
      idle(1);
      waited++;
    end
    chk("wait_bit3", (waited < 200), 1'b1);
    cycle(1'b1, '0, '0, 4'b0000);
    chk("rst_tx", oTx, 1'b1);
    idle(FRAME + 10);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        cycle(1'b1, '0, '0, 4'b0000);
      end else if ($urandom_range(0, 2) == 0) begin
        case ($urandom_range(0, 5))
          0, 1, 2: a = CON;
          3:       a = HLT;
          4:       a = CON + 8;
          default: a = $urandom;
        endcase
        cycle(1'b0, a, $urandom, 4'($urandom_range(0, 15)));
      end else begin
        idle(1);
      end
    end
    idle(DEPTH * (FRAME + 1) + 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
